// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: bus source codes, ALU opcodes
// and default datapath widths, used by the datapath, controller and encoders.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_ZERO = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_ASHL  = 3'd1,
        ALU_XNOR  = 3'd2,
        ALU_DIV2  = 3'd3,
        ALU_LOAD  = 3'd4,
        ALU_STORE = 3'd5,
        ALU_COMP  = 3'd6,
        ALU_ROUND = 3'd7
    } alu_op_e;

endpackage

// File: rtl/ctrl_reg.sv
// Register template with synchronous reset and clear > load > inc priority;
// increment wraps modulo 2**W.
module ctrl_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State update: reset and clear both zero the register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/risc_alu.sv
// Combinational ALU: x is the accumulator, y the data register. Ops that do
// not define carry/overflow pass c_in/v_in straight through.
module risc_alu
    import cpu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [2:0]   op,
    input  logic         c_in,
    input  logic         v_in,
    output logic [W-1:0] result,
    output logic         c,
    output logic         v,
    output logic         z
);

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W:0] sum_s;

    // Function select and flag generation
    always_comb begin
        sum_s  = {1'b0, x} + {1'b0, y};
        result = y;
        c      = c_in;
        v      = v_in;
        case (alu_op_e'(op))
            ALU_ADD: begin
                result = sum_s[W-1:0];
                c      = sum_s[W];
                v      = (x[W-1] == y[W-1]) && (sum_s[W-1] != x[W-1]);
            end
            ALU_ASHL: begin
                result = {y[W-2:0], 1'b0};
                c      = y[W-1];
                v      = y[W-1] ^ y[W-2];
            end
            ALU_XNOR:  result = ~(x ^ y);
            ALU_DIV2: begin
                result = {y[W-1], y[W-1:1]};
                c      = y[0];
                v      = 1'b0;
            end
            ALU_LOAD:  result = y;
            ALU_STORE: result = x;
            ALU_COMP: begin
                result = ~y + ONE;
                c      = (y == '0);
                v      = (y == SMIN);
            end
            ALU_ROUND: begin
                // Rounding the largest positive value would flip the sign, so clamp it
                if (x == SMAX) begin
                    result = SMAX;
                    v      = 1'b1;
                end else begin
                    result = x + {{(W-1){1'b0}}, x[0]};
                    v      = 1'b0;
                end
                c = 1'b0;
            end
            default: begin
                result = y;
                c      = c_in;
                v      = v_in;
            end
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/risc_datapath.sv
// Accumulator-CPU datapath: IR/PC/AR/DR/AC on a common bus, ALU with flags,
// and a word-addressed RAM with asynchronous read and synchronous write.
module risc_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loadIR,
    input  logic              incIR,
    input  logic              clearIR,
    input  logic              loadDR,
    input  logic              incDR,
    input  logic              clearDR,
    input  logic              loadPC,
    input  logic              incPC,
    input  logic              clearPC,
    input  logic              loadAR,
    input  logic              incAR,
    input  logic              clearAR,
    input  logic              loadAC,
    input  logic              incAC,
    input  logic              clearAC,
    input  logic [2:0]        busSelectors,
    input  logic [2:0]        aluOpcode,
    input  logic              read,
    input  logic              write,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] AC,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] AR,
    output logic [DATA_W-1:0] DR,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_v,
    output logic [DATA_W-1:0] bus
);

    logic [DATA_W-1:0] memArray_r [MEM_DEPTH];
    logic [DATA_W-1:0] bus_s;
    logic [DATA_W-1:0] aluResult_s;
    logic              aluC_s;
    logic              aluV_s;
    logic              aluZ_s;
    logic              unusedRead_s;

    // The bus source comes from busSelectors alone; read is only a strobe for observers
    assign unusedRead_s = read;
    assign bus          = bus_s;

    // Common bus source mux
    always_comb begin
        bus_s = '0;
        case (bus_sel_e'(busSelectors))
            BUS_NONE: bus_s = '0;
            BUS_AR:   bus_s = DATA_W'(AR);
            BUS_PC:   bus_s = DATA_W'(PC);
            BUS_DR:   bus_s = DR;
            BUS_AC:   bus_s = AC;
            BUS_IR:   bus_s = IR;
            BUS_ZERO: bus_s = '0;
            BUS_MEM:  bus_s = memArray_r[AR];
            default:  bus_s = '0;
        endcase
    end

    risc_alu #(.W(DATA_W)) uAlu (
        .x(AC), .y(DR), .op(aluOpcode), .c_in(flag_c), .v_in(flag_v),
        .result(aluResult_s), .c(aluC_s), .v(aluV_s), .z(aluZ_s)
    );

    ctrl_reg #(.W(DATA_W)) uIr (
        .clk(clk), .reset(reset), .load(loadIR), .inc(incIR), .clear(clearIR),
        .d(bus_s), .q(IR)
    );

    ctrl_reg #(.W(DATA_W)) uDr (
        .clk(clk), .reset(reset), .load(loadDR), .inc(incDR), .clear(clearDR),
        .d(bus_s), .q(DR)
    );

    ctrl_reg #(.W(DATA_W)) uAc (
        .clk(clk), .reset(reset), .load(loadAC), .inc(incAC), .clear(clearAC),
        .d(aluResult_s), .q(AC)
    );

    ctrl_reg #(.W(ADDR_W)) uPc (
        .clk(clk), .reset(reset), .load(loadPC), .inc(incPC), .clear(clearPC),
        .d(bus_s[ADDR_W-1:0]), .q(PC)
    );

    // A simultaneous loadAR/incAR resolves to the load inside the template
    ctrl_reg #(.W(ADDR_W)) uAr (
        .clk(clk), .reset(reset), .load(loadAR), .inc(incAR), .clear(clearAR),
        .d(bus_s[ADDR_W-1:0]), .q(AR)
    );

    // Flags follow whichever accumulator action wins its priority
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else if (clearAC) begin
            flag_c <= 1'b0;
            flag_z <= 1'b1;
            flag_v <= 1'b0;
        end else if (loadAC) begin
            flag_c <= aluC_s;
            flag_z <= aluZ_s;
            flag_v <= aluV_s;
        end else if (incAC) begin
            flag_z <= (AC == '1);
        end
    end

    // RAM write port: boot/test writes take priority, nothing commits during reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (prog_we) begin
                memArray_r[prog_addr] <= prog_data;
            end else if (write) begin
                memArray_r[AR] <= AC;
            end
        end
    end

endmodule
